// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes and FSM state encoding.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_MUL    = 3'd2,
    ALU_DIV    = 3'd3,
    ALU_SHL    = 3'd4,
    ALU_SHR    = 3'd5,
    ALU_PASS_A = 3'd6,
    ALU_RSVD   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative datapath: shift-add multiply (mode=0) or restoring divide (mode=1),
// one bit per step on a {hi, lo} accumulator. hi_nxt/lo_nxt expose the value
// the current step produces so the caller can register it on the final step.
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum, rem_sh, trial;

  assign last = (cnt_q == LAST_CNT);

  // One multiply or divide iteration applied to the current accumulator
  always_comb begin
    sum    = '0;
    rem_sh = '0;
    trial  = '0;
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (!mode) begin
      sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_in} : '0);
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      rem_sh = {hi_q, lo_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, b_in};
      if (!trial[WIDTH]) begin
        hi_nxt = trial[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Accumulator and iteration counter update
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (load) begin
      hi_d  = '0;
      lo_d  = a_in;
      cnt_d = '0;
    end else if (step) begin
      hi_d  = hi_nxt;
      lo_d  = lo_nxt;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Multi-cycle ALU: start/busy/done handshake, single-cycle ops resolved on the
// accepting edge, MUL/DIV delegated to the iterative datapath.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             a_sel,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             dz
);

  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH:0]   add_sum;
  logic             shift_oob;
  logic [WIDTH-1:0] res_sc;
  logic             carry_sc;
  logic             load, step, last;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign a_in = a_sel ? din_b : din_a;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .mode   (op_q == ALU_DIV),
    .a_in   (a_in),
    .b_in   (b_q),
    .hi_nxt (md_hi),
    .lo_nxt (md_lo),
    .last   (last)
  );

  // Single-cycle op results from the live inputs on the accepting edge
  always_comb begin
    add_sum   = {1'b0, a_in} + {1'b0, din};
    shift_oob = (din >= W_LIM);
    res_sc    = '0;
    carry_sc  = 1'b0;
    case (alu_op_e'(op))
      ALU_ADD: begin
        res_sc   = add_sum[WIDTH-1:0];
        carry_sc = add_sum[WIDTH];
      end
      ALU_SUB: begin
        res_sc   = a_in - din;
        carry_sc = (a_in < din);
      end
      ALU_SHL:    res_sc = shift_oob ? '0 : (a_in << din[SHW-1:0]);
      ALU_SHR:    res_sc = shift_oob ? '0 : (a_in >> din[SHW-1:0]);
      ALU_PASS_A: res_sc = a_in;
      default:    res_sc = '0;
    endcase
  end

  // FSM next state, operand capture and result/flag update on DONE entry
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    b_d         = b_q;
    load        = 1'b0;
    step        = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = alu_op_e'(op);
          b_d  = din;
          load = 1'b1;
          case (alu_op_e'(op))
            ALU_MUL: state_d = S_MUL;
            ALU_DIV: begin
              if (din != '0) begin
                state_d = S_DIV;
              end else begin
                state_d     = S_DONE;
                result_d    = '1;
                result_hi_d = a_in;
                zero_d      = 1'b0;
                carry_d     = 1'b0;
                ovf_d       = 1'b0;
                dz_d        = 1'b1;
              end
            end
            default: begin
              state_d     = S_DONE;
              result_d    = res_sc;
              result_hi_d = '0;
              zero_d      = (res_sc == '0);
              carry_d     = carry_sc;
              ovf_d       = 1'b0;
              dz_d        = 1'b0;
            end
          endcase
        end
      end
      S_MUL, S_DIV: begin
        step = 1'b1;
        if (last) begin
          state_d     = S_DONE;
          result_d    = md_lo;
          result_hi_d = md_hi;
          zero_d      = (md_lo == '0);
          carry_d     = 1'b0;
          ovf_d       = (state_q == S_MUL) && (md_hi != '0);
          dz_d        = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured operands and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= ALU_ADD;
      b_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      b_q         <= b_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule
